// File: rtl/layer_mac_sequencer.sv
// Dense-layer sequencer: one signed 16x16 MAC shared across all neurons, bias add, saturate, write.
// Optional build macro LAYER_RELU_EN clamps negative results to zero (hidden layers).
module layer_mac_sequencer #(
  parameter int INPUT_SIZE    = 784,
  parameter int NUM_NEURONS   = 16,
  parameter int IN_ADDR_W     = 10,
  parameter int NEURON_ADDR_W = 4,
  parameter int W_ADDR_W      = 14
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [IN_ADDR_W-1:0]     in_addr,
  input  logic [15:0]              in_data,
  output logic [W_ADDR_W-1:0]      w_addr,
  input  logic [15:0]              w_data,
  output logic [NEURON_ADDR_W-1:0] b_addr,
  input  logic [15:0]              b_data,
  output logic                     out_we,
  output logic [NEURON_ADDR_W-1:0] out_addr,
  output logic [15:0]              out_data
);

  typedef enum logic [2:0] {IDLE, MAC, FLUSH, WRITE, DONE} state_t;

  localparam logic [IN_ADDR_W-1:0]     LAST_I = IN_ADDR_W'(INPUT_SIZE - 1);
  localparam logic [NEURON_ADDR_W-1:0] LAST_N = NEURON_ADDR_W'(NUM_NEURONS - 1);
  localparam logic [W_ADDR_W-1:0]      N_W    = W_ADDR_W'(INPUT_SIZE);

  state_t                   state, state_nx;
  logic [NEURON_ADDR_W-1:0] neuron;
  logic [W_ADDR_W-1:0]      base;
  logic signed [41:0]       acc, acc_nx;
  logic signed [31:0]       prod;
  logic signed [42:0]       sum, shifted;
  logic [15:0]              sat, result;
  logic                     mac_vld;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = MAC;
      MAC:     if (in_addr == LAST_I) state_nx = FLUSH;
      FLUSH:   state_nx = WRITE;
      WRITE:   state_nx = (neuron == LAST_N) ? DONE : MAC;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy   = (state == MAC) || (state == FLUSH) || (state == WRITE);
  assign done   = (state == DONE);
  assign b_addr = neuron;

  // ROM data lags its address by one cycle, so mac_vld marks cycles whose data belongs to a MAC address.
  assign prod    = $signed(in_data) * $signed(w_data);
  assign acc_nx  = acc + (mac_vld ? 42'(prod) : 42'sd0);
  assign sum     = 43'(acc_nx) + (43'($signed(b_data)) <<< 15);
  assign shifted = sum >>> 15;

  always_comb begin
    if (shifted > 43'sd32767)       sat = 16'h7FFF;
    else if (shifted < -43'sd32768) sat = 16'h8000;
    else                            sat = shifted[15:0];
`ifdef LAYER_RELU_EN
    result = sat[15] ? 16'h0000 : sat;
`else
    result = sat;
`endif
  end

  // Result is registered on the FLUSH edge so the write strobe, address and data are all clean flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neuron   <= '0;
      base     <= '0;
      in_addr  <= '0;
      w_addr   <= '0;
      acc      <= '0;
      mac_vld  <= 1'b0;
      out_we   <= 1'b0;
      out_addr <= '0;
      out_data <= '0;
    end else begin
      mac_vld <= (state == MAC);
      out_we  <= 1'b0;
      case (state)
        IDLE: if (start) begin
          neuron  <= '0;
          base    <= '0;
          in_addr <= '0;
          w_addr  <= '0;
          acc     <= '0;
        end
        MAC: begin
          acc <= acc_nx;
          if (in_addr != LAST_I) begin
            in_addr <= in_addr + 1'b1;
            w_addr  <= w_addr + 1'b1;
          end
        end
        FLUSH: begin
          acc      <= acc_nx;
          out_we   <= 1'b1;
          out_addr <= neuron;
          out_data <= result;
        end
        WRITE: begin
          acc <= '0;
          if (neuron != LAST_N) begin
            neuron  <= neuron + 1'b1;
            base    <= base + N_W;
            w_addr  <= base + N_W;
            in_addr <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_mac_sequencer.sv
// Scoreboard bench for layer_mac_sequencer at N=4, M=2 with hand-computed expected writes.
module tb_layer_mac_sequencer;
  localparam int N = 4;
  localparam int M = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, out_we;
  logic [9:0]  in_addr;
  logic [13:0] w_addr;
  logic [3:0]  b_addr, out_addr;
  logic [15:0] in_data, w_data, b_data, out_data;

  logic [15:0] in_mem [N];
  logic [15:0] w_mem  [N*M];
  logic [15:0] b_mem  [M];

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] data;
    int          cyc;
  } wr_t;

  wr_t sb[$];
  int  dq[$];
  int  cyc = 0, t0 = 0;
  int  nchk = 0, npass = 0;

  layer_mac_sequencer #(
    .INPUT_SIZE(N), .NUM_NEURONS(M), .IN_ADDR_W(10), .NEURON_ADDR_W(4), .W_ADDR_W(14)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .in_addr(in_addr), .in_data(in_data), .w_addr(w_addr), .w_data(w_data),
    .b_addr(b_addr), .b_data(b_data), .out_we(out_we), .out_addr(out_addr), .out_data(out_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    in_data <= in_mem[in_addr[1:0]];
    w_data  <= w_mem[w_addr[2:0]];
    b_data  <= b_mem[b_addr[0]];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Monitor: every write strobe and done pulse is matched against the queues.
  always @(negedge clk) begin
    if (rst_n && out_we) begin
      if (sb.size() == 0) chk("unexpected_write", {28'd0, out_addr}, 32'hFFFF_FFFF);
      else begin
        wr_t e;
        e = sb.pop_front();
        chk("out_addr", {28'd0, out_addr}, {28'd0, e.addr});
        chk("out_data", {16'd0, out_data}, {16'd0, e.data});
        chk("write_cycle", cyc - t0, e.cyc);
      end
    end
    if (rst_n && done) begin
      if (dq.size() == 0) chk("unexpected_done", cyc - t0, 32'hFFFF_FFFF);
      else chk("done_cycle", cyc - t0, dq.pop_front());
    end
  end

  task automatic load(input logic [15:0] in [N], input logic [15:0] w [N*M],
                      input logic [15:0] b0, input logic [15:0] b1);
    for (int i = 0; i < N; i++) in_mem[i] = in[i];
    for (int i = 0; i < N*M; i++) w_mem[i] = w[i];
    b_mem[0] = b0;
    b_mem[1] = b1;
  endtask

  task automatic run_pass(input logic [15:0] e0, input logic [15:0] e1, input bit spam, input bit addr_chk);
    wr_t e;
    @(negedge clk);
    start = 1'b1;
    t0 = cyc;
    e.addr = 4'd0; e.data = e0; e.cyc = N + 2;       sb.push_back(e);
    e.addr = 4'd1; e.data = e1; e.cyc = 2 * (N + 2); sb.push_back(e);
    dq.push_back(M * (N + 2) + 1);
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      start = spam && (c == 3 || c == 13);
      if (addr_chk) begin
        if (c == 1)  chk("w_addr_c1",  {18'd0, w_addr}, 32'd0);
        if (c == 4)  chk("w_addr_c4",  {18'd0, w_addr}, 32'd3);
        if (c == 5)  chk("w_addr_flush", {18'd0, w_addr}, 32'd3);
        if (c == 7)  chk("w_addr_c7",  {18'd0, w_addr}, 32'd4);
        if (c == 10) chk("w_addr_c10", {18'd0, w_addr}, 32'd7);
        if (c == 10) chk("in_addr_c10", {22'd0, in_addr}, 32'd3);
        if (c == 12) chk("b_addr_c12", {28'd0, b_addr}, 32'd1);
      end
      if (spam && c == 15) chk("busy_after_ignored_start", {31'd0, busy}, 32'd0);
    end
    start = 1'b0;
    chk("writes_outstanding", sb.size(), 32'd0);
    chk("done_outstanding", dq.size(), 32'd0);
  endtask

  logic [15:0] va_in [N], va_w [N*M];
  logic [15:0] vs_in [N], vs_w [N*M];
  logic [15:0] vn_w [N*M];
  logic [15:0] vm_in [N], vm_w [N*M];
  logic [15:0] neg_exp, mix_exp;

  initial begin
    va_in = '{16'h2000, 16'h2000, 16'h2000, 16'h2000};
    va_w  = '{16'h2000, 16'h2000, 16'h2000, 16'h2000, 16'h2000, 16'h2000, 16'h2000, 16'h2000};
    vs_in = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    vs_w  = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    vn_w  = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000};
    // 0.5, -0.5, 0.25, 0.125 against two weight rows; neuron 0 floors to -4098, neuron 1 to 2.
    vm_in = '{16'h4000, 16'hC000, 16'h2000, 16'h1000};
    vm_w  = '{16'h4000, 16'h4000, 16'h8000, 16'h7FFF, 16'h0001, 16'h0001, 16'h0001, 16'h0001};
`ifdef LAYER_RELU_EN
    neg_exp = 16'h0000;
    mix_exp = 16'h0000;
`else
    neg_exp = 16'h8000;
    mix_exp = 16'hEFFE;
`endif
    load(va_in, va_w, 16'h0100, 16'h0000);

    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_out_we", {31'd0, out_we}, 32'd0);
    chk("rst_w_addr", {18'd0, w_addr}, 32'd0);
    chk("rst_out_data", {16'd0, out_data}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_pass(16'h2100, 16'h2000, 1'b0, 1'b1);

    load(vs_in, vs_w, 16'h7FFF, 16'h7FFF);
    run_pass(16'h7FFF, 16'h7FFF, 1'b0, 1'b0);

    load(vs_in, vn_w, 16'h0000, 16'h0000);
    run_pass(neg_exp, neg_exp, 1'b0, 1'b0);

    load(vm_in, vm_w, 16'hFFFF, 16'h0002);
    run_pass(mix_exp, 16'h0002, 1'b0, 1'b0);

    load(va_in, va_w, 16'h0100, 16'h0000);
    run_pass(16'h2100, 16'h2000, 1'b1, 1'b0);

    // Abort mid-MAC: saturating data left in the ROMs would poison a stale accumulator.
    load(vs_in, vs_w, 16'h7FFF, 16'h7FFF);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_out_we", {31'd0, out_we}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    load(va_in, va_w, 16'h0100, 16'h0000);
    @(negedge clk);
    run_pass(16'h2100, 16'h2000, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
